// File: rtl/mannix_job_sched.sv
// In-order job dispatcher for the FCC/POOL/CNN engines with one job in flight per engine and a serialised completion stream.
// Optional watchdog abort per busy engine is enabled by defining MANNIX_SCHED_TIMEOUT_EN.
module mannix_job_sched #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TAG_W          = 4,
  parameter int LEVEL_W        = $clog2(FIFO_DEPTH) + 1,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_engine,
  input  logic               cmd_barrier,
  input  logic [TAG_W-1:0]   cmd_tag,
  input  logic               sched_flush,
  output logic               fc_go,
  output logic               pool_go,
  output logic               cnn_go,
  input  logic               fc_done,
  input  logic               pool_done,
  input  logic               cnn_done,
  output logic               cmpl_valid,
  output logic [1:0]         cmpl_engine,
  output logic [TAG_W-1:0]   cmpl_tag,
  output logic               cmpl_err,
  output logic [LEVEL_W-1:0] fifo_level,
  output logic               sched_idle
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NE = 3;

  typedef struct packed {
    logic [1:0]       engine;
    logic             barrier;
    logic [TAG_W-1:0] tag;
  } desc_t;

  typedef enum logic [1:0] {SLOT_IDLE, SLOT_BUSY, SLOT_PEND} slot_t;

  desc_t              mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [LEVEL_W-1:0] count;
  logic               full, empty, push, pop;
  desc_t              head;

  slot_t              slot_q [NE];
  slot_t              slot_d [NE];
  logic [TAG_W-1:0]   slot_tag [NE];
  logic [NE-1:0]      slot_err_q, slot_err_d;
  logic               err_pend_q, err_pend_d;
  logic [TAG_W-1:0]   err_tag_q;

  logic [NE-1:0]      done_vec, tmo;
  logic [3:0]         eng_free;
  logic               all_idle, head_ok, dispatch, err_pop;
  logic               rep_vld, rep_err;
  logic [1:0]         rep_eng;
  logic [TAG_W-1:0]   rep_tag;

  assign full       = (count == LEVEL_W'(FIFO_DEPTH));
  assign empty      = (count == '0);
  assign cmd_ready  = !full && !sched_flush;
  assign push       = cmd_valid && cmd_ready;
  assign head       = mem[rd_ptr];
  assign fifo_level = count;
  assign done_vec   = {cnn_done, pool_done, fc_done};

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_engine, cmd_barrier, cmd_tag};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      // Flush drops everything queued; a same-cycle pop has already been taken into a slot.
      if (sched_flush) begin
        rd_ptr <= wr_ptr;
        count  <= '0;
      end else begin
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      count <= count + 1'b1;
        else if (!push && pop) count <= count - 1'b1;
      end
    end
  end

  // Code 3 never occupies an engine, so it is always "free" for the head check.
  assign eng_free   = {1'b1, slot_q[2] == SLOT_IDLE, slot_q[1] == SLOT_IDLE, slot_q[0] == SLOT_IDLE};
  assign all_idle   = (&eng_free[2:0]) && !err_pend_q;
  assign head_ok    = !empty && !err_pend_q && eng_free[head.engine] && (!head.barrier || all_idle);
  assign dispatch   = head_ok && (head.engine != 2'd3);
  assign err_pop    = head_ok && (head.engine == 2'd3);
  assign pop        = head_ok;
  assign sched_idle = empty && all_idle;

`ifdef MANNIX_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tmo_cnt [NE];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NE; i++) tmo_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NE; i++) begin
        if (dispatch && head.engine == 2'(i)) tmo_cnt[i] <= '0;
        else if (slot_q[i] == SLOT_BUSY && tmo_cnt[i] != CW'(TIMEOUT_CYCLES)) tmo_cnt[i] <= tmo_cnt[i] + 1'b1;
      end
    end
  end

  always_comb begin
    tmo = '0;
    for (int i = 0; i < NE; i++) tmo[i] = (slot_q[i] == SLOT_BUSY) && (tmo_cnt[i] == CW'(TIMEOUT_CYCLES));
  end
`else
  assign tmo = '0;
`endif

  always_comb begin
    slot_d     = slot_q;
    slot_err_d = slot_err_q;
    err_pend_d = err_pend_q;
    rep_vld    = 1'b0;
    rep_eng    = 2'd0;
    rep_tag    = '0;
    rep_err    = 1'b0;
    for (int i = 0; i < NE; i++) begin
      if (slot_q[i] == SLOT_BUSY && (done_vec[i] || tmo[i])) begin
        slot_d[i]     = SLOT_PEND;
        slot_err_d[i] = !done_vec[i];
      end
    end
    // Descending scan so the lowest engine index (highest priority) wins.
    for (int i = NE - 1; i >= 0; i--) begin
      if (slot_d[i] == SLOT_PEND) begin
        rep_vld = 1'b1;
        rep_eng = 2'(i);
        rep_tag = slot_tag[i];
        rep_err = slot_err_d[i];
      end
    end
    if (!rep_vld && err_pend_q) begin
      rep_vld    = 1'b1;
      rep_eng    = 2'd3;
      rep_tag    = err_tag_q;
      rep_err    = 1'b1;
      err_pend_d = 1'b0;
    end
    for (int i = 0; i < NE; i++) begin
      if (rep_vld && rep_eng == 2'(i)) slot_d[i] = SLOT_IDLE;
      if (dispatch && head.engine == 2'(i)) begin
        slot_d[i]     = SLOT_BUSY;
        slot_err_d[i] = 1'b0;
      end
    end
    if (err_pop) err_pend_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NE; i++) begin
        slot_q[i]   <= SLOT_IDLE;
        slot_tag[i] <= '0;
      end
      slot_err_q  <= '0;
      err_pend_q  <= 1'b0;
      err_tag_q   <= '0;
      fc_go       <= 1'b0;
      pool_go     <= 1'b0;
      cnn_go      <= 1'b0;
      cmpl_valid  <= 1'b0;
      cmpl_engine <= 2'd0;
      cmpl_tag    <= '0;
      cmpl_err    <= 1'b0;
    end else begin
      for (int i = 0; i < NE; i++) begin
        slot_q[i] <= slot_d[i];
        if (dispatch && head.engine == 2'(i)) slot_tag[i] <= head.tag;
      end
      slot_err_q  <= slot_err_d;
      err_pend_q  <= err_pend_d;
      if (err_pop) err_tag_q <= head.tag;
      fc_go       <= dispatch && (head.engine == 2'd0);
      pool_go     <= dispatch && (head.engine == 2'd1);
      cnn_go      <= dispatch && (head.engine == 2'd2);
      cmpl_valid  <= rep_vld;
      cmpl_engine <= rep_eng;
      cmpl_tag    <= rep_tag;
      cmpl_err    <= rep_err;
    end
  end

endmodule
